// File: rtl/rst_seq_lock.sv
// rst_seq_lock: PLL/core reset sequencer.
// Pulses the PLL reset, waits for a stable synchronized lock (with timeout and
// retry), holds the core in reset for a fixed time, then releases it. Lock loss
// restarts the whole sequence; a soft request re-runs only the core hold.
//
// Ports:
//   clk          in   clock (PLL clk_out1)
//   reset        in   synchronous active-high reset
//   locked       in   PLL lock, asynchronous to clk
//   soft_rst_req in   single-cycle request to re-reset the core only
//   pll_reset    out  PLL reset, active high
//   rst_n        out  core reset, active low
//   ready        out  high while in RUN
//   relock_cnt   out  saturating count of PLL retries and lock losses
module rst_seq_lock #(
  parameter int unsigned CW           = 16,
  parameter int unsigned PLL_RST_CYC  = 4,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned HOLD_CYC     = 32,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  input  logic       soft_rst_req,
  output logic       pll_reset,
  output logic       rst_n,
  output logic       ready,
  output logic [7:0] relock_cnt
);

  localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_HOLD,
    S_RUN
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [CW-1:0]   stb, stb_nx;
  logic [7:0]      relock_nx;
  logic            relock_inc;
  logic            lock_m, locked_s;

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_m   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      lock_m   <= locked;
      locked_s <= lock_m;
    end
  end

  // State, counters and outputs; outputs decode the next state so they
  // change on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_PLL_RST;
      cnt        <= '0;
      stb        <= '0;
      relock_cnt <= 8'd0;
      pll_reset  <= 1'b1;
      rst_n      <= 1'b0;
      ready      <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      stb        <= stb_nx;
      relock_cnt <= relock_nx;
      pll_reset  <= (state_nx == S_PLL_RST);
      rst_n      <= (state_nx == S_RUN);
      ready      <= (state_nx == S_RUN);
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    stb_nx     = stb;
    relock_inc = 1'b0;

    case (state)
      S_PLL_RST: begin
        cnt_nx = cnt + CW'(1);
        if (cnt == PLL_LAST) begin
          state_nx = S_WAIT_LOCK;
          cnt_nx   = '0;
          stb_nx   = '0;
        end
      end

      S_WAIT_LOCK: begin
        cnt_nx = cnt + CW'(1);
        stb_nx = locked_s ? stb + CW'(1) : '0;
        // Stable lock wins over a simultaneous timeout
        if (locked_s && (stb == STB_LAST)) begin
          state_nx = S_HOLD;
          cnt_nx   = '0;
        end else if (cnt == TO_LAST) begin
          state_nx   = S_PLL_RST;
          cnt_nx     = '0;
          relock_inc = 1'b1;
        end
      end

      S_HOLD: begin
        cnt_nx = cnt + CW'(1);
        if (!locked_s) begin
          state_nx   = S_PLL_RST;
          cnt_nx     = '0;
          relock_inc = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          state_nx = S_RUN;
        end
      end

      S_RUN: begin
        // Lock loss has priority over a soft request
        if (!locked_s) begin
          state_nx   = S_PLL_RST;
          cnt_nx     = '0;
          relock_inc = 1'b1;
        end else if (soft_rst_req) begin
          state_nx = S_HOLD;
          cnt_nx   = '0;
        end
      end

      default: begin
        state_nx = S_PLL_RST;
        cnt_nx   = '0;
        stb_nx   = '0;
      end
    endcase

    relock_nx = (relock_inc && (relock_cnt != 8'hFF)) ? relock_cnt + 8'd1 : relock_cnt;
  end

endmodule

// File: doc/rst_seq_lock.md
Name: rst_seq_lock

Overview:
- Consumes the clock wizard's `locked` output and its `clk_out1` domain.
- Drives the wizard's `reset` input.
- Produces the clean active-low core reset `rst_n` for the RV32I CPU and its peripherals.
- Sequence: pulses the PLL reset, waits for a stable lock (with timeout and retry), holds the core in reset for a fixed time, then releases it. Lock loss or a soft reset request restarts the sequence.

Parameters:
- CW, 16, width of the shared cycle counter; every cycle parameter below must be ≤ 2^CW.
- PLL_RST_CYC, 4, number of cycles `pll_reset` is held high per attempt.
- LOCK_STABLE, 16, number of consecutive cycles with synced lock high required before leaving WAIT_LOCK.
- HOLD_CYC, 32, number of cycles the core reset is held after a stable lock.
- LOCK_TIMEOUT, 1024, number of cycles in WAIT_LOCK before a PLL retry.

Ports:
- clk  input  1  system clock (`clk_out1` from the PLL).
- reset  input  1  synchronous, active-high reset.
- locked  input  1  PLL lock indication; asynchronous to clk.
- soft_rst_req  input  1  single-cycle request to re-reset the core without resetting the PLL.
- pll_reset  output  1  reset to the PLL (wizard `reset` input); active high.
- rst_n  output  1  core reset; active low.
- ready  output  1  high while the sequence is in RUN.
- relock_cnt  output  8  saturating count of PLL retries and lock losses.

Behaviour:
- Lock synchronizer:
  - `locked` passes through a 2-flop synchronizer to give `locked_s`; both flops reset to 0.
  - Only `locked_s` is used by the FSM, so lock changes take effect 2 cycles late.
- FSM states: PLL_RST, WAIT_LOCK, HOLD, RUN.
- Counters: one cycle counter `cnt` (CW bits), a separate stable counter `stb` (CW bits), and `relock_cnt`.
- Reset (`reset`=1 at a clk edge):
  - state=PLL_RST, cnt=0, stb=0, relock_cnt=0, both sync flops=0.
  - Outputs become pll_reset=1, rst_n=0, ready=0.
- Outputs are a registered decode of the state register with no extra latency:
  - pll_reset=(state==PLL_RST).
  - rst_n=(state==RUN).
  - ready=(state==RUN).
- PLL_RST:
  - cnt increments each cycle.
  - When cnt==PLL_RST_CYC-1: go to WAIT_LOCK, cnt=0, stb=0.
  - `pll_reset` is therefore high for exactly PLL_RST_CYC cycles.
- WAIT_LOCK:
  - cnt increments each cycle (timeout).
  - If locked_s==1: stb increments; otherwise stb clears to 0.
  - If locked_s==1 and stb==LOCK_STABLE-1: go to HOLD, cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1: go to PLL_RST, cnt=0, relock_cnt+1.
  - If both conditions hold in the same cycle, the lock success wins.
- HOLD:
  - cnt increments each cycle.
  - If locked_s==0: go to PLL_RST, cnt=0, relock_cnt+1.
  - Else if cnt==HOLD_CYC-1: go to RUN.
  - `soft_rst_req` is ignored in HOLD.
- RUN:
  - If locked_s==0: go to PLL_RST, cnt=0, relock_cnt+1. `rst_n` falls on the next edge.
  - Else if soft_rst_req==1: go to HOLD, cnt=0. `relock_cnt` is unchanged and the PLL is not reset.
  - Lock loss has priority over `soft_rst_req`.
- `soft_rst_req` in PLL_RST or WAIT_LOCK: ignored.
- `relock_cnt` saturates at 255; it never wraps.
- Reset asserted mid-sequence: immediate return to reset values on that edge, from any state.
- Nominal startup latency with `locked` tied to 1 and default parameters:
  - The first edge with reset=0 is edge 1.
  - Edge 4: PLL_RST → WAIT_LOCK.
  - Edge 20: WAIT_LOCK → HOLD.
  - Edge 52: HOLD → RUN.
  - So rst_n=1 and ready=1 after edge 52 (PLL_RST_CYC + LOCK_STABLE + HOLD_CYC).
- `locked_s` glitch in WAIT_LOCK (one-cycle drop): stb clears to 0 and counting restarts. cnt is not cleared, so the timeout keeps running.

Test Plan:
- Locked tied 1, deassert reset → pll_reset high for edges 1–4, rst_n=0 through edge 51, rst_n=1 and ready=1 after edge 52, relock_cnt=0.
- Locked held 0 → after 4 + 1024 edges the FSM returns to PLL_RST (pll_reset high 4 cycles), relock_cnt=1; two full timeouts give relock_cnt=2.
- In RUN, drop `locked` for 1 cycle → rst_n=0 three edges later (2 sync + 1 state), relock_cnt+1; with lock restored, rst_n=1 again after 52 edges.
- In RUN, pulse `soft_rst_req` → rst_n=0 next edge, pll_reset stays 0, rst_n=1 after 32 edges, relock_cnt unchanged; lock loss and soft request in the same cycle → PLL_RST taken.
- Locked toggles every 10 cycles (stable run never reaches 16) → no exit to HOLD, timeout retry at 1024; force 300 retries → relock_cnt=255 (saturated).
- Assert reset during HOLD at cnt=17 → next edge gives pll_reset=1, rst_n=0, ready=0, relock_cnt=0; after release, the startup latency is again exactly 52 edges.
